tt_mux_ctrl_seq: RTL and testbench
==================================

# tt_mux_ctrl_seq

Upstream control sequencer for the tile multiplexer's control interface. It drives `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena` so that a requested design address is selected and enabled without software bit-banging.

- It accepts a single address request.
- It resets the selection chain, emits exactly `address` increment pulses, then asserts enable.
- It sits between the housekeeping/register front end and the mux control pads (io_in[36], io_in[34], io_in[32]).

## Interface

Parameters:
- `ADDR_W`, 10, width of the design address (selects up to 2^ADDR_W designs).
- `PULSE_W`, 2, cycles per half-period of every control pulse (≥1).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe.
- `req_addr`  in  ADDR_W  target design address; sampled only at accept.
- `req_ena`  in  1  1 = assert `ctrl_ena` after selection; 0 = select only. Sampled at accept.
- `req_ready`  out  1  sequencer can accept a request.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when the sequence completes.
- `cur_addr`  out  ADDR_W  last fully selected address.
- `ctrl_sel_rst_n`  out  1  selection-chain reset, active low.
- `ctrl_sel_inc`  out  1  selection-chain increment pulse.
- `ctrl_ena`  out  1  enable for the selected design.

## Operation

All outputs are registered.

Reset values:
- `ctrl_sel_rst_n`=0 (chain held at address 0 while in reset).
- `ctrl_sel_inc`=0, `ctrl_ena`=0.
- `req_ready`=1, `busy`=0, `done`=0, `cur_addr`=0.
- State=IDLE.

State machine (one-hot or encoded; implementer's choice):
- **IDLE**: `ctrl_sel_rst_n`=1, inc=0, ena=0, ready=1. On `req_valid`: latch `req_addr` and `req_ena`, go to RST_LO.
- **RST_LO**: `ctrl_sel_rst_n`=0 for PULSE_W cycles, then go to RST_HI.
- **RST_HI**: `ctrl_sel_rst_n`=1 for PULSE_W cycles.
  - If the remaining increment count is 0, go to FINISH; otherwise go to INC_HI.
- **INC_HI**: `ctrl_sel_inc`=1 for PULSE_W cycles, then go to INC_LO.
- **INC_LO**: `ctrl_sel_inc`=0 for PULSE_W cycles, then decrement the remaining count.
  - If the count is now 0, go to FINISH; otherwise go to INC_HI.
- **FINISH** (single transition, no dwell): `ctrl_ena` ← latched `req_ena`, `cur_addr` ← latched addr, `done`=1 for one cycle, go to ACTIVE.
- **ACTIVE**: ready=1, outputs held. A new `req_valid` is accepted exactly as in IDLE; on accept `ctrl_ena` drops to 0 in the same edge as `ctrl_sel_rst_n` falls.

Status and handshake rules:
- `busy`=1 in RST_LO through INC_LO; `req_ready` = !busy.
- Requests while busy are ignored (not queued).
- `ctrl_sel_rst_n` and `ctrl_sel_inc` are never both active in the same cycle.
- `ctrl_ena` is 0 throughout RST_LO..INC_LO.

Counters and widths:
- Half-period counter: width clog2(PULSE_W), minimum 1 bit.
- Increment counter: ADDR_W bits, loaded with `req_addr`, counts down to 0; no wrap.
- `req_addr` = 2^ADDR_W−1 is legal.

## Timing

Latency, with the accept at edge E0 (`req_valid`·`req_ready` high before E0):
- `ctrl_sel_rst_n` low after E0 and high after E0+P (P = PULSE_W).
- Increment k (k = 0..addr−1) is high from E0+2P+2Pk to E0+3P+2Pk.
- `ctrl_ena`, `done`, `cur_addr` and `req_ready` update after E0+2P(addr+1).
- For addr=0, that completion point is E0+2P.

Reset mid-operation:
- `reset_n` low forces all outputs to their reset values asynchronously.
- In particular `ctrl_ena`=0 and `ctrl_sel_rst_n`=0 immediately.
- The latched request is discarded.

Reset release:
- The first clock edge after `reset_n` rises enters IDLE behaviour with `ctrl_sel_rst_n`=1.

## Test plan

- **Reset**: hold `reset_n`=0, toggle clk → `ctrl_sel_rst_n`=0, inc=0, ena=0, ready=1, `cur_addr`=0. Release → `ctrl_sel_rst_n`=1 after the next edge.
- **Address 0**: P=2, addr=0, ena=1 → exactly 0 inc pulses; rst_n low 2 cycles; `ctrl_ena`=1 and `done` pulse 4 cycles after accept.
- **Address 5**: P=2, addr=5, ena=1 → exactly 5 inc pulses, each 2 cycles high / 2 low; `ctrl_ena` rises 24 cycles after accept; `cur_addr`=5.
- **Busy and reselect**: assert `req_valid` with addr=9 while busy on addr=5 → ignored, final `cur_addr`=5. Then request addr=3 from ACTIVE → `ctrl_ena` falls on the accept edge, 3 inc pulses, `cur_addr`=3.
- **Reset mid-sequence**: pulse `reset_n` low during the 3rd INC_HI → inc=0, ena=0 and rst_n=0 within the same cycle, no `done`. A subsequent addr=2 request completes normally.
- **Select only / max address**: addr=2^ADDR_W−1, ena=0, P=1 → 1023 inc pulses; `ctrl_ena` stays 0; `done` at 2048 cycles after accept; `cur_addr`=1023.

Source files
------------

// File: rtl/tt_mux_ctrl_seq.sv
// Tile-mux control sequencer: resets the selection chain,
// pulses increment address times, then applies enable.
module tt_mux_ctrl_seq #(
  parameter int ADDR_W  = 10,
  parameter int PULSE_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int HW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [HW-1:0] HLAST = HW'(PULSE_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    RST_LO,
    RST_HI,
    INC_HI,
    INC_LO,
    ACTIVE
  } state_t;

  state_t            state, state_d;
  logic [HW-1:0]     hcnt, hcnt_d;
  logic [ADDR_W-1:0] icnt, icnt_d;
  logic [ADDR_W-1:0] lat_addr, lat_addr_d;
  logic              lat_ena, lat_ena_d;
  logic              ready_d, busy_d, done_d;
  logic [ADDR_W-1:0] cur_d;
  logic              sel_rst_d, inc_d, ena_d;
  logic              hlast;
  logic              fin;

  assign hlast = (hcnt == HLAST);

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hcnt           <= '0;
      icnt           <= '0;
      lat_addr       <= '0;
      lat_ena        <= 1'b0;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      cur_addr       <= '0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state          <= state_d;
      hcnt           <= hcnt_d;
      icnt           <= icnt_d;
      lat_addr       <= lat_addr_d;
      lat_ena        <= lat_ena_d;
      req_ready      <= ready_d;
      busy           <= busy_d;
      done           <= done_d;
      cur_addr       <= cur_d;
      ctrl_sel_rst_n <= sel_rst_d;
      ctrl_sel_inc   <= inc_d;
      ctrl_ena       <= ena_d;
    end
  end

  // Next state and next output values; the finish step
  // is folded into the edge that leaves RST_HI/INC_LO.
  always_comb begin
    state_d    = state;
    hcnt_d     = hcnt;
    icnt_d     = icnt;
    lat_addr_d = lat_addr;
    lat_ena_d  = lat_ena;
    ready_d    = req_ready;
    busy_d     = busy;
    done_d     = 1'b0;
    cur_d      = cur_addr;
    sel_rst_d  = ctrl_sel_rst_n;
    inc_d      = ctrl_sel_inc;
    ena_d      = ctrl_ena;
    fin        = 1'b0;

    unique case (state)
      IDLE, ACTIVE: begin
        if (state == IDLE) begin
          sel_rst_d = 1'b1;
          inc_d     = 1'b0;
          ena_d     = 1'b0;
        end
        if (req_valid) begin
          state_d    = RST_LO;
          hcnt_d     = '0;
          icnt_d     = req_addr;
          lat_addr_d = req_addr;
          lat_ena_d  = req_ena;
          sel_rst_d  = 1'b0;
          inc_d      = 1'b0;
          ena_d      = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
        end
      end
      RST_LO: begin
        if (hlast) begin
          state_d   = RST_HI;
          hcnt_d    = '0;
          sel_rst_d = 1'b1;
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      RST_HI: begin
        if (hlast) begin
          hcnt_d = '0;
          if (icnt == '0) begin
            fin = 1'b1;
          end else begin
            state_d = INC_HI;
            inc_d   = 1'b1;
          end
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      INC_HI: begin
        if (hlast) begin
          state_d = INC_LO;
          hcnt_d  = '0;
          inc_d   = 1'b0;
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      INC_LO: begin
        if (hlast) begin
          hcnt_d = '0;
          icnt_d = icnt - ADDR_W'(1);
          if (icnt == ADDR_W'(1)) begin
            fin = 1'b1;
          end else begin
            state_d = INC_HI;
            inc_d   = 1'b1;
          end
        end else begin
          hcnt_d = hcnt + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d = ACTIVE;
      ena_d   = lat_ena;
      cur_d   = lat_addr;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_tt_mux_ctrl_seq.sv
// Directed bench for tt_mux_ctrl_seq: one PULSE_W=2
// instance for timing cases, one PULSE_W=1 for max address.
module tb_tt_mux_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       v2 = 1'b0, e2 = 1'b0;
  logic [9:0] a2 = '0;
  logic       rdy2, bsy2, dn2, srst2, inc2, ena2;
  logic [9:0] cur2;

  logic       v1 = 1'b0, e1 = 1'b0;
  logic [9:0] a1 = '0;
  logic       rdy1, bsy1, dn1, srst1, inc1, ena1;
  logic [9:0] cur1;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tt_mux_ctrl_seq #(.ADDR_W(10), .PULSE_W(2)) u_p2 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(v2), .req_addr(a2), .req_ena(e2),
    .req_ready(rdy2), .busy(bsy2), .done(dn2),
    .cur_addr(cur2), .ctrl_sel_rst_n(srst2),
    .ctrl_sel_inc(inc2), .ctrl_ena(ena2)
  );

  tt_mux_ctrl_seq #(.ADDR_W(10), .PULSE_W(1)) u_p1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(v1), .req_addr(a1), .req_ena(e1),
    .req_ready(rdy1), .busy(bsy1), .done(dn1),
    .cur_addr(cur1), .ctrl_sel_rst_n(srst1),
    .ctrl_sel_inc(inc1), .ctrl_ena(ena1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected increment level for P=2, n samples after accept.
  function automatic logic exp_inc(input int n, input int a);
    if (n < 4 || n >= 4 + 4 * a) return 1'b0;
    return ((n - 4) % 4) < 2;
  endfunction

  task automatic run_p2(input int a, input logic e,
                        input int exp_n, input bit inj);
    int n;
    int incs;
    bit seen;
    logic prev;
    chk("ready_pre", rdy2, 1);
    v2 = 1'b1; a2 = 10'(a); e2 = e;
    tick();
    v2 = 1'b0; a2 = '0; e2 = 1'b0;
    n = 0; incs = 0; seen = 0; prev = 1'b0;
    while (!seen && n <= exp_n + 8) begin
      if (n < exp_n) begin
        chk("inc_wave", inc2, exp_inc(n, a));
        chk("sel_rst_wave", srst2, (n >= 2));
        chk("ena_busy", ena2, 0);
        chk("busy", bsy2, 1);
        chk("ready_busy", rdy2, 0);
        chk("done_early", dn2, 0);
      end
      if (inc2 && !prev) incs++;
      prev = inc2;
      if (dn2) begin
        seen = 1;
        chk("done_time", n, exp_n);
      end else begin
        if (inj && n == 6) begin
          v2 = 1'b1; a2 = 10'd9; e2 = 1'b1;
        end else begin
          v2 = 1'b0; a2 = '0; e2 = 1'b0;
        end
        tick();
        n++;
      end
    end
    v2 = 1'b0;
    chk("done_seen", seen, 1);
    chk("inc_count", incs, a);
    chk("ena_final", ena2, e);
    chk("cur_addr", cur2, a);
    chk("ready_final", rdy2, 1);
    chk("busy_final", bsy2, 0);
    tick();
    chk("done_1cyc", dn2, 0);
    chk("ena_hold", ena2, e);
  endtask

  initial begin
    int n;
    int incs;
    bit seen;
    bit ena_seen;
    logic prev;

    // Reset held with clock running
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_sel_rst_n", srst2, 0);
    chk("rst_inc", inc2, 0);
    chk("rst_ena", ena2, 0);
    chk("rst_ready", rdy2, 1);
    chk("rst_busy", bsy2, 0);
    chk("rst_done", dn2, 0);
    chk("rst_cur", cur2, 0);
    reset_n = 1'b1;
    #2;
    chk("rel_pre_edge", srst2, 0);
    tick();
    chk("rel_sel_rst_n", srst2, 1);
    chk("rel_p1_sel_rst_n", srst1, 1);
    tick();

    // Address 0: done 4 cycles after accept
    run_p2(0, 1'b1, 4, 1'b0);
    // Address 5 with ignored request for 9 while busy
    run_p2(5, 1'b1, 24, 1'b1);
    // Reselect from ACTIVE: ena drops at accept edge
    run_p2(3, 1'b1, 16, 1'b0);

    // Reset during third INC_HI (samples 12,13 after accept)
    v2 = 1'b1; a2 = 10'd3; e2 = 1'b1;
    tick();
    v2 = 1'b0; a2 = '0; e2 = 1'b0;
    repeat (12) tick();
    chk("mid_inc_hi", inc2, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_inc", inc2, 0);
    chk("mid_rst_ena", ena2, 0);
    chk("mid_rst_sel", srst2, 0);
    chk("mid_rst_done", dn2, 0);
    chk("mid_rst_cur", cur2, 0);
    chk("mid_rst_ready", rdy2, 1);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rel_sel", srst2, 1);
    chk("mid_rel_done", dn2, 0);
    run_p2(2, 1'b1, 12, 1'b0);

    // Max address, select only, P=1
    v1 = 1'b1; a1 = 10'd1023; e1 = 1'b0;
    tick();
    v1 = 1'b0; a1 = '0;
    n = 0; incs = 0; seen = 0; ena_seen = 0; prev = 1'b0;
    while (!seen && n <= 2100) begin
      if (inc1 && !prev) incs++;
      prev = inc1;
      if (ena1) ena_seen = 1;
      if (dn1) begin
        seen = 1;
      end else begin
        tick();
        n++;
      end
    end
    chk("max_done_seen", seen, 1);
    chk("max_done_time", n, 2048);
    chk("max_inc_count", incs, 1023);
    chk("max_ena_low", ena_seen, 0);
    chk("max_cur_addr", cur1, 1023);
    chk("max_ready", rdy1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
